// File: rtl/key_counter.sv
// Two-button up/down counter (0..9999) with synchronizers, debounce and optional auto-repeat.
// Define KEY_COUNTER_AUTOREPEAT_EN to enable hold-then-repeat stepping; default is one step per press.
module key_counter #(
   parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
   parameter logic [23:0] HOLD_CYC     = 24'd8000000,
   parameter logic [23:0] REPEAT_CYC   = 24'd2000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        add,
   input  logic        sub,
   input  logic        clr,
   output logic [15:0] data,
   output logic        upd,
   output logic        at_max,
   output logic        at_min
);

   localparam logic [15:0] MAX_VAL  = 16'd9999;
   localparam logic [23:0] DB_FULL  = {8'd0, DEBOUNCE_CYC};
   // A debounce length of 0 or 1 means the entry edge alone accepts the press.
   localparam bit          DB_IMMED = (DB_FULL < 24'd2);
   localparam logic [23:0] DB_LAST  = DB_IMMED ? 24'd0 : DB_FULL - 24'd2;
`ifdef KEY_COUNTER_AUTOREPEAT_EN
   localparam logic [23:0] HOLD_LAST = (HOLD_CYC == 24'd0) ? 24'd0 : HOLD_CYC - 24'd1;
   localparam logic [23:0] REP_LAST  = (REPEAT_CYC == 24'd0) ? 24'd0 : REPEAT_CYC - 24'd1;

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, REPEAT} state_t;
`else
   typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD} state_t;
`endif

   typedef enum logic [1:0] {PAT_NONE, PAT_INC, PAT_DEC} pat_t;

   logic [1:0]  add_sync;
   logic [1:0]  sub_sync;
   pat_t        pat;
   state_t      state;
   logic [23:0] cnt;
   logic        dir_inc;
   logic        step_inc;
   logic        match;
   logic [15:0] step_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_sync <= 2'b11;
         sub_sync <= 2'b11;
      end else begin
         add_sync <= {add_sync[0], add};
         sub_sync <= {sub_sync[0], sub};
      end
   end

   always_comb begin
      pat = PAT_NONE;
      if (!add_sync[1] && sub_sync[1])
         pat = PAT_INC;
      else if (add_sync[1] && !sub_sync[1])
         pat = PAT_DEC;
   end

   assign match    = (pat == (dir_inc ? PAT_INC : PAT_DEC));
   // From IDLE the step (immediate debounce only) follows the fresh pattern, not the stale latch.
   assign step_inc = (state == IDLE) ? (pat == PAT_INC) : dir_inc;

   always_comb begin
      step_val = data;
      if (step_inc) begin
         if (data < MAX_VAL)
            step_val = data + 16'd1;
      end else if (data != 16'd0) begin
         step_val = data - 16'd1;
      end
   end

   task automatic apply_step();
      if (step_val != data) begin
         data <= step_val;
         upd  <= 1'b1;
      end
   endtask

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 24'd0;
         dir_inc <= 1'b1;
         data    <= 16'd0;
         upd     <= 1'b0;
      end else begin
         upd <= 1'b0;
         if (clr) begin
            state <= IDLE;
            cnt   <= 24'd0;
            data  <= 16'd0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= 24'd0;
                  if (pat != PAT_NONE) begin
                     dir_inc <= (pat == PAT_INC);
                     if (DB_IMMED) begin
                        apply_step();
                        state <= HOLD;
                     end else begin
                        state <= DEBOUNCE;
                     end
                  end
               end
               DEBOUNCE: begin
                  if (!match) begin
                     state <= IDLE;
                     cnt   <= 24'd0;
                  end else if (cnt == DB_LAST) begin
                     apply_step();
                     state <= HOLD;
                     cnt   <= 24'd0;
                  end else begin
                     cnt <= cnt + 24'd1;
                  end
               end
`ifdef KEY_COUNTER_AUTOREPEAT_EN
               HOLD: begin
                  if (!match) begin
                     state <= IDLE;
                     cnt   <= 24'd0;
                  end else if (cnt == HOLD_LAST) begin
                     apply_step();
                     state <= REPEAT;
                     cnt   <= 24'd0;
                  end else begin
                     cnt <= cnt + 24'd1;
                  end
               end
               REPEAT: begin
                  if (!match) begin
                     state <= IDLE;
                     cnt   <= 24'd0;
                  end else if (cnt == REP_LAST) begin
                     apply_step();
                     cnt <= 24'd0;
                  end else begin
                     cnt <= cnt + 24'd1;
                  end
               end
`else
               HOLD: begin
                  cnt <= 24'd0;
                  if (!match)
                     state <= IDLE;
               end
`endif
               default: begin
                  state <= IDLE;
                  cnt   <= 24'd0;
               end
            endcase
         end
      end
   end

   assign at_max = (data == MAX_VAL);
   assign at_min = (data == 16'd0);

endmodule

// File: tb/tb_key_counter.sv
// Bench for key_counter: run-length reference model checked every cycle, directed cases plus random presses.
module tb_key_counter;

   localparam int D = 4;
   localparam int H = 20;
   localparam int R = 5;
`ifdef KEY_COUNTER_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        add = 1'b1;
   logic        sub = 1'b1;
   logic        clr = 1'b0;
   logic [15:0] data;
   logic        upd;
   logic        at_max;
   logic        at_min;

   int n_chk  = 0;
   int n_fail = 0;

   key_counter #(
      .DEBOUNCE_CYC(16'(D)),
      .HOLD_CYC    (24'(H)),
      .REPEAT_CYC  (24'(R))
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .add   (add),
      .sub   (sub),
      .clr   (clr),
      .data  (data),
      .upd   (upd),
      .at_max(at_max),
      .at_min(at_min)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the press is a run of identical non-NONE patterns (raw input seen two edges late).
   // A direct switch INC<->DEC or a clear consumes one edge before a new run can start.
   logic [1:0] ha = 2'b11;
   logic [1:0] hs = 2'b11;
   int run = 0;
   int mdir = 0;
   int pcur = 0;
   int m_data = 0;
   int nd = 0;
   logic m_upd = 1'b0;

   function automatic bit is_step(input int r);
      if (r == D) return 1'b1;
      if (AR && r >= D + H && ((r - D - H) % R) == 0) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ha = 2'b11; hs = 2'b11; run = 0; mdir = 0; m_data = 0; m_upd = 1'b0;
      end else begin
         pcur  = (!ha[1] && hs[1]) ? 1 : (ha[1] && !hs[1]) ? 2 : 0;
         m_upd = 1'b0;
         if (clr) begin
            run = 0; m_data = 0;
         end else if (pcur == 0 || (run > 0 && pcur != mdir)) begin
            run = 0;
         end else begin
            run++; mdir = pcur;
            if (is_step(run)) begin
               nd = (mdir == 1) ? ((m_data < 9999) ? m_data + 1 : m_data)
                                : ((m_data > 0) ? m_data - 1 : m_data);
               if (nd != m_data) begin m_data = nd; m_upd = 1'b1; end
            end
         end
         ha = {ha[0], add};
         hs = {hs[0], sub};
      end
   end

   always @(negedge clk) begin
      check("data", data, m_data);
      check("upd", upd, m_upd);
      check("at_max", at_max, (m_data == 9999));
      check("at_min", at_min, (m_data == 0));
   end

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int base;
      int len;
      int kind;
      base = AR ? 3 : 1;

      // reset state
      cyc(2);
      check("rst_data", data, 0);
      check("rst_upd", upd, 0);
      check("rst_at_min", at_min, 1);
      check("rst_at_max", at_max, 0);
      rst = 1'b0;
      cyc(2);

      // single long press: latency and hold/repeat timing
      add = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         if (k == 5) check("press_e5", data, 0);
         if (k == 6) begin check("press_e6", data, 1); check("press_e6_upd", upd, 1); end
         if (k == 7) check("press_e7_upd", upd, 0);
         if (k == 25) check("press_e25", data, 1);
         if (AR && k == 26) begin check("press_e26", data, 2); check("press_e26_upd", upd, 1); end
         if (k == 31) check("press_e31", data, base);
         if (k == 30) add = 1'b1;
      end
      cyc(5);

      // bounce shorter than debounce
      repeat (5) begin
         add = 1'b0; cyc(3);
         add = 1'b1; cyc(2);
      end
      cyc(3);
      check("bounce", data, base);

      // second key mid-hold, then a short sub press
      add = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 10) check("both_e10", data, base + 1);
         if (k == 14) sub = 1'b0;
         if (k == 25) begin add = 1'b1; sub = 1'b1; end
      end
      cyc(4);
      check("both_after", data, base + 1);
      sub = 1'b0; cyc(10);
      sub = 1'b1; cyc(5);
      check("sub_once", data, base);

      // clear coincident with a debounce step
      add = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 5) clr = 1'b1;
         if (k == 6) begin clr = 1'b0; check("clr_data", data, 0); check("clr_upd", upd, 0); end
         if (k == 9) check("clr_e9", data, 0);
         if (k == 10) check("clr_e10", data, 1);
      end
      add = 1'b1; cyc(5);

      // saturation at zero
      sub = 1'b0; cyc(30);
      check("min_data", data, 0);
      check("min_flag", at_min, 1);
      sub = 1'b1; cyc(5);

      // long hold, then async reset in the middle of a cycle
      add = 1'b0;
      for (int k = 1; k <= 203; k++) begin
         @(negedge clk);
         if (k == 201) check("hold_e201", data, AR ? 37 : 1);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check("rst_mid_data", data, 0);
      check("rst_mid_upd", upd, 0);
      cyc(2);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 5) check("rerel_e5", data, 0);
         if (k == 6) check("rerel_e6", data, 1);
      end
      add = 1'b1; cyc(5);

      // random presses, chatter and clears
      for (int i = 0; i < 400; i++) begin
         kind = $urandom_range(0, 3);
         len  = $urandom_range(1, AR ? 40 : 12);
         add  = !(kind == 1 || kind == 3);
         sub  = !(kind == 2 || kind == 3);
         clr  = ($urandom_range(0, 15) == 0);
         @(negedge clk);
         clr = 1'b0;
         if (len > 1) cyc(len - 1);
      end
      add = 1'b1; sub = 1'b1; clr = 1'b0;
      cyc(5);

      // climb to the top and saturate there
      for (int i = 0; i < 12000 && m_data != 9999; i++) begin
         add = 1'b0; cyc(4);
         add = 1'b1; cyc(1);
      end
      cyc(3);
      check("climb", data, 9999);
      add = 1'b0; cyc(100);
      check("max_data", data, 9999);
      check("max_flag", at_max, 1);
      add = 1'b1; cyc(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
